nibble_serial_adder: RTL and testbench
======================================

Name: nibble_serial_adder

Overview:
- Multi-cycle word adder/subtractor built around a 4-bit ripple slice of full-adder cells.
- The controller sits directly upstream of the 4-bit slice. Each cycle it feeds the slice one operand nibble pair plus the registered carry, then collects the nibble sum.
- It assembles a W-bit result with carryout and two's-complement overflow.
- It trades latency for area against a flat W-bit ripple adder.

Parameters:
- NIBBLES, 4, number of 4-bit slices per operation; word width W = 4*NIBBLES; legal range 1..8.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled on a rising edge only when the block is not busy.
- sub  input  1  0 = a+b, 1 = a-b; latched with the operands at start.
- a  input  W  first operand, two's complement; latched at start.
- b  input  W  second operand, two's complement; latched at start.
- busy  output  1  high while a computation is in progress.
- done  output  1  single-cycle pulse; sum, carryout and overflow are valid from this cycle on.
- sum  output  W  result word.
- carryout  output  1  carry out of bit W-1; for subtract, 1 = no borrow.
- overflow  output  1  signed overflow of the full W-bit operation.

Behaviour:
- Reset: asynchronous on rst_n low; clock and reset polarity/synchronicity are fixed as stated.
  - State goes to IDLE.
  - busy=0, done=0, sum=0, carryout=0, overflow=0.
  - Operand registers, nibble index and carry register are cleared.
- States: IDLE, RUN, DONE.
- IDLE or DONE with start=1 at an edge:
  - latch a, b and sub;
  - if sub=1, latch b as ~b and preset the carry register to 1; otherwise preset carry to 0;
  - set nibble index to 0 and go to RUN.
- IDLE with start=0: stay in IDLE.
- DONE with start=0: go to IDLE.
- RUN, each edge:
  - Slice inputs are nibble[idx] of the latched a, nibble[idx] of the latched b, and the carry register.
  - Store the 4-bit slice sum into result nibble idx of an internal result register.
  - Register the slice carry-out into the carry register.
  - If idx = NIBBLES-1:
    - copy the internal result to sum;
    - set carryout = slice carry-out;
    - set overflow = carry into bit 3 XOR carry out of bit 3 of the final slice;
    - go to DONE.
  - Otherwise increment idx.
- Outputs:
  - busy = (state==RUN).
  - done = (state==DONE), exactly one cycle wide per accepted start.
- Latency: start accepted at edge E0 → done high during the cycle after edge E(NIBBLES). Throughput is one op per NIBBLES+1 cycles.
- Result hold: sum, carryout and overflow change only on the final RUN edge and hold between operations. Partial results are never visible on sum.
- start while busy: ignored, no queuing; the operands on a/b at that time have no effect.
- start in the DONE cycle: accepted (back-to-back). done still pulses for the completed op.
- a, b and sub changing during RUN: no effect.
- Reset mid-RUN: aborts the op and clears all outputs; no done pulse follows.
- Arithmetic: modulo 2^W. Subtract is implemented as a + ~b + 1.
- NIBBLES=1: a single RUN cycle; done follows 1 edge after start.

Test Plan:
- Add 0x00FF+0x0001 with NIBBLES=4 → sum=0x0100, carryout=0, overflow=0; busy high for 4 cycles; done pulses exactly 4 edges after the start edge.
- Add 0x7FFF+0x0001 → sum=0x8000, overflow=1, carryout=0. Add 0xFFFF+0x0001 → sum=0x0000, carryout=1, overflow=0.
- Subtract 0x0005-0x0007 → sum=0xFFFE, carryout=0, overflow=0. Subtract 0x8000-0x0001 → sum=0x7FFF, overflow=1, carryout=1.
- Pulse start with a=0x1111 two cycles into a 0x1234+0x0001 op → ignored; result is 0x1235 and only one done pulse occurs.
- Hold start high with new operands through the DONE cycle → second op accepted there; two done pulses 5 cycles apart, each with the correct sum.
- Drop rst_n for 1 cycle during RUN (idx=2) → busy, done, sum and flags go to 0 immediately; no done afterwards; the next start computes correctly.

Source files
------------

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: multi-cycle W-bit adder/subtractor built around one
// 4-bit ripple slice. Each RUN cycle processes one operand nibble, least
// significant first, and the slice carry is registered between cycles.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   start     request, honoured when not busy (IDLE or DONE)
//   sub       0 = a+b, 1 = a-b, latched at start
//   a, b      W-bit two's-complement operands, latched at start
//   busy      high while RUN
//   done      one-cycle pulse; results valid from this cycle on
//   sum       W-bit result, updated only when an operation completes
//   carryout  carry out of bit W-1 (for subtract, 1 = no borrow)
//   overflow  signed overflow of the full W-bit operation

// One full-adder cell.
module nsa_full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);
  assign o_sum  = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

// 4-bit ripple slice; exposes the carry into bit 3 for overflow detection.
module nsa_slice4 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_sum,
  output logic       o_c3,
  output logic       o_cout
);
  logic [4:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar g = 0; g < 4; g++) begin : g_cell
    nsa_full_adder u_fa (
      .i_a    (i_a[g]),
      .i_b    (i_b[g]),
      .i_cin  (w_c[g]),
      .o_sum  (o_sum[g]),
      .o_cout (w_c[g+1])
    );
  end

  assign o_c3   = w_c[3];
  assign o_cout = w_c[4];
endmodule

module nibble_serial_adder #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   sub,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   carryout,
  output logic                   overflow
);
  localparam int unsigned W    = 4 * NIBBLES;
  localparam int unsigned IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;       // already inverted for subtract
  logic [W-1:0]    r_res;     // partial result, never driven onto sum
  logic [IDXW-1:0] r_idx;
  logic            r_carry;

  logic [W-1:0]    w_a_shift;
  logic [W-1:0]    w_b_shift;
  logic [3:0]      w_a_nib;
  logic [3:0]      w_b_nib;
  logic [3:0]      w_nib_sum;
  logic            w_c3;
  logic            w_cout;
  logic [W-1:0]    w_res_next;
  logic            w_last;
  logic            w_accept;

  // Select the current nibble pair by shifting it down to bit 0.
  assign w_a_shift = r_a >> {r_idx, 2'b00};
  assign w_b_shift = r_b >> {r_idx, 2'b00};
  assign w_a_nib   = w_a_shift[3:0];
  assign w_b_nib   = w_b_shift[3:0];

  nsa_slice4 u_slice (
    .i_a    (w_a_nib),
    .i_b    (w_b_nib),
    .i_cin  (r_carry),
    .o_sum  (w_nib_sum),
    .o_c3   (w_c3),
    .o_cout (w_cout)
  );

  // Partial result with the current slice output merged into nibble idx.
  always_comb begin
    w_res_next = r_res;
    for (int n = 0; n < int'(NIBBLES); n++) begin
      if (r_idx == IDXW'(n)) begin
        w_res_next[4*n +: 4] = w_nib_sum;
      end
    end
  end

  assign w_last   = (r_idx == IDXW'(NIBBLES - 1));
  assign w_accept = start && (r_state != ST_RUN);

  // Controller, datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_idx    <= '0;
      r_carry  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      carryout <= 1'b0;
      overflow <= 1'b0;
    end else if (w_accept) begin
      // Subtract runs as a + ~b + 1: invert b here and seed the carry.
      r_state <= ST_RUN;
      r_a     <= a;
      r_b     <= sub ? ~b : b;
      r_carry <= sub;
      r_idx   <= '0;
      busy    <= 1'b1;
      done    <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          busy <= 1'b0;
          done <= 1'b0;
        end
        ST_RUN: begin
          r_res   <= w_res_next;
          r_carry <= w_cout;
          if (w_last) begin
            sum      <= w_res_next;
            carryout <= w_cout;
            overflow <= w_c3 ^ w_cout;
            r_state  <= ST_DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Testbench for nibble_serial_adder (NIBBLES=4, W=16): directed cases plus
// random operations compared against an integer-arithmetic reference.
module tb_nibble_serial_adder;
  localparam int unsigned NIB = 4;
  localparam int unsigned W   = 4 * NIB;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         carryout;
  logic         overflow;

  int errors = 0;
  int checks = 0;

  nibble_serial_adder #(.NIBBLES(NIB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .carryout (carryout),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: signed/unsigned integer arithmetic on the operand values.
  task automatic model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                       output logic [W-1:0] es, output logic ec, output logic eo);
    int sx, sy, sr;
    longint ux, uy;
    sx = int'($signed(x));
    sy = int'($signed(y));
    ux = longint'(x);
    uy = longint'(y);
    sr = s ? (sx - sy) : (sx + sy);
    eo = (sr > 32767) || (sr < -32768);
    ec = s ? (ux >= uy) : ((ux + uy) > 65535);
    es = s ? W'(ux - uy) : W'(ux + uy);
  endtask

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                        input string tag);
    logic [W-1:0] es;
    logic ec, eo;
    int edges, busy_cnt;
    bit seen;
    model(x, y, s, es, ec, eo);
    @(negedge clk);
    a = x; b = y; sub = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); sub = ~s;  // must not disturb the op
    edges = 0; busy_cnt = 0; seen = 0;
    while (1) begin
      if (busy) busy_cnt++;
      if (done) begin seen = 1; break; end
      if (edges == 20) break;
      @(posedge clk); #1;
      edges++;
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_latency"}, 32'(edges), 32'(NIB));
    chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(NIB));
    chk({tag, "_sum"}, 32'(sum), 32'(es));
    chk({tag, "_carry"}, 32'(carryout), 32'(ec));
    chk({tag, "_ovf"}, 32'(overflow), 32'(eo));
    @(posedge clk); #1;
    chk({tag, "_done_single"}, 32'(done), 32'd0);
    chk({tag, "_sum_hold"}, 32'(sum), 32'(es));
  endtask

  initial begin
    int pulses, t1, t2;
    bit first_seen;
    logic [W-1:0] s1;
    logic [W-1:0] s2;

    rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_carry", 32'(carryout), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Directed arithmetic cases.
    run_op(16'h00FF, 16'h0001, 1'b0, "add_00ff");
    run_op(16'h7FFF, 16'h0001, 1'b0, "add_7fff");
    run_op(16'hFFFF, 16'h0001, 1'b0, "add_ffff");
    run_op(16'h0005, 16'h0007, 1'b1, "sub_5_7");
    run_op(16'h8000, 16'h0001, 1'b1, "sub_8000");
    run_op(16'h0000, 16'h0000, 1'b1, "sub_0_0");

    // Start pulsed mid-operation must be ignored.
    @(negedge clk);
    a = 16'h1234; b = 16'h0001; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    a = 16'h1111; b = 16'h1111; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    pulses = 0; s1 = '0;
    for (int k = 0; k < 12; k++) begin
      if (done) begin pulses++; s1 = sum; end
      @(posedge clk); #1;
    end
    chk("ignore_pulses", 32'(pulses), 32'd1);
    chk("ignore_sum", 32'(s1), 32'h1235);

    // Start held high through DONE: back-to-back acceptance.
    @(negedge clk);
    a = 16'h0F0F; b = 16'h0101; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    a = 16'h0003; b = 16'h0005; sub = 1'b1;
    pulses = 0; t1 = 0; t2 = 0; first_seen = 0; s1 = '0; s2 = '0;
    for (int cyc = 1; cyc <= 16; cyc++) begin
      @(posedge clk); #1;
      if (first_seen && start) start = 1'b0;
      if (done) begin
        pulses++;
        if (pulses == 1) begin t1 = cyc; s1 = sum; first_seen = 1; end
        else begin t2 = cyc; s2 = sum; end
      end
    end
    start = 1'b0;
    chk("b2b_pulses", 32'(pulses), 32'd2);
    chk("b2b_first_lat", 32'(t1), 32'(NIB));
    chk("b2b_spacing", 32'(t2 - t1), 32'(NIB + 1));
    chk("b2b_sum1", 32'(s1), 32'h1010);
    chk("b2b_sum2", 32'(s2), 32'hFFFE);

    // Reset mid-RUN after non-zero results are on the outputs.
    run_op(16'h8000, 16'h0001, 1'b1, "pre_abort");
    @(negedge clk);
    a = 16'h2222; b = 16'h1111; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_sum", 32'(sum), 32'd0);
    chk("abort_carry", 32'(carryout), 32'd0);
    chk("abort_ovf", 32'(overflow), 32'd0);
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (done || busy) pulses++;
    end
    chk("abort_no_done", 32'(pulses), 32'd0);
    run_op(16'h2222, 16'h1111, 1'b0, "post_abort");

    // Random operations.
    for (int i = 0; i < 40; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
